uart_rx_ovs: RTL and testbench

Parametrised oversampling UART receiver, the successor to the fixed 8-bit, 3x-sampled receiver. It adds configurable data width, oversample ratio and stop bits, and reports parity, framing and break errors per word. Output uses a valid/ready handshake with overrun detection, and an optional output FIFO. It sits between the asynchronous `rx` pad and any host-side consumer (register bank, DMA, protocol parser).

---
 rtl/uart_rx_ovs.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx_ovs.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: oversampling UART receiver with majority vote, parity/framing/break detection and valid/ready output.
// Defining UART_RX_FIFO_EN replaces the single output register with a FIFO_DEPTH-entry show-ahead FIFO.
module uart_rx_ovs #(
  parameter int DATA_BITS  = 8,
  parameter int OVS        = 16,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 stop2,
  input  logic                 rx,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_perr,
  output logic                 m_ferr,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 busy
);
  localparam int OW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [OW-1:0] ovs_q, ovs_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [1:0] smp_q, smp_d;
  logic pen_q, pen_d, podd_q, podd_d, s2_q, s2_d, arm_q, arm_d;
  logic perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d, pvote_q, pvote_d;
  logic ovr_q, brk_out_q;
  logic rxs, tick, vote_pt, bit_end, vote, done;
  logic [DATA_BITS+1:0] word;
  assign rxs = sync_q[1];
  assign tick = div_q == baud_div;
  assign vote_pt = tick && ovs_q == OW'(OVS / 2 + 1);
  assign bit_end = tick && ovs_q == OW'(OVS - 1);
  assign vote = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);
  assign word = {data_q, perr_q, ferr_d};
  assign busy = state_q != IDLE;
  assign overrun = ovr_q;
  assign break_det = brk_out_q;
  always_comb begin
    state_d = state_q;
    ovs_d = tick ? (bit_end ? '0 : ovs_q + 1'b1) : ovs_q;
    bit_d = bit_q;
    data_d = data_q;
    smp_d = smp_q;
    pen_d = pen_q;
    podd_d = podd_q;
    s2_d = s2_q;
    arm_d = (tick && rxs) ? 1'b1 : arm_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    brk_d = brk_q;
    pvote_d = pvote_q;
    done = 1'b0;
    div_d = (tick || div_q > baud_div) ? '0 : div_q + 1'b1;
    if (tick && ovs_q == OW'(OVS / 2 - 1)) smp_d[0] = rxs;
    if (tick && ovs_q == OW'(OVS / 2)) smp_d[1] = rxs;
    case (state_q)
      IDLE: begin
        ovs_d = '0;
        if (tick && !rxs && arm_q) begin
          state_d = START;
          bit_d = '0;
          pen_d = parity_en;
          podd_d = parity_odd;
          s2_d = stop2;
          perr_d = 1'b0;
          ferr_d = 1'b0;
          brk_d = 1'b0;
          pvote_d = 1'b0;
        end
      end
      START: begin
        if (vote_pt && vote) state_d = IDLE;
        else if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (vote_pt) data_d = {vote, data_q[DATA_BITS-1:1]};
        if (bit_end) begin
          bit_d = bit_q == BW'(DATA_BITS - 1) ? '0 : bit_q + 1'b1;
          if (bit_q == BW'(DATA_BITS - 1)) state_d = pen_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (vote_pt) begin
          perr_d = vote ^ (^data_q) ^ podd_q;
          pvote_d = vote;
        end
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (vote_pt) begin
          ferr_d = ferr_q | ~vote;
          // break is judged on the first stop vote; a second stop bit only affects ferr
          if (bit_q == '0) brk_d = data_q == '0 && !pvote_q && !vote;
          if (bit_q != '0 || !s2_q) begin
            done = 1'b1;
            state_d = IDLE;
          end
        end
        if (bit_end) bit_d = BW'(1);
      end
      default: state_d = IDLE;
    endcase
    if (done && ferr_d) arm_d = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q <= 2'b11;
      div_q <= '0;
      ovs_q <= '0;
      bit_q <= '0;
      data_q <= '0;
      smp_q <= '0;
      {pen_q, podd_q, s2_q} <= '0;
      arm_q <= 1'b1;
      {perr_q, ferr_q, brk_q, pvote_q} <= '0;
      brk_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= {sync_q[0], rx};
      div_q <= div_d;
      ovs_q <= ovs_d;
      bit_q <= bit_d;
      data_q <= data_d;
      smp_q <= smp_d;
      {pen_q, podd_q, s2_q} <= {pen_d, podd_d, s2_d};
      arm_q <= arm_d;
      {perr_q, ferr_q, brk_q, pvote_q} <= {perr_d, ferr_d, brk_d, pvote_d};
      brk_out_q <= done && brk_d;
    end
  end
`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_BITS+1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic full, pop, push;
  assign full = cnt_q == (AW + 1)'(FIFO_DEPTH);
  assign pop = m_valid && m_ready;
  assign push = done && (!full || pop);
  assign m_valid = cnt_q != '0;
  assign {m_data, m_perr, m_ferr} = m_valid ? mem_q[rp_q] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      if (push) mem_q[wp_q] <= word;
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
      ovr_q <= done && !push;
    end
  end
`else
  logic [DATA_BITS+1:0] out_q;
  logic vld_q, load;
  assign load = done && (!vld_q || m_ready);
  assign m_valid = vld_q;
  assign {m_data, m_perr, m_ferr} = out_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      vld_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      if (load) out_q <= word;
      vld_q <= load || (vld_q && !m_ready);
      ovr_q <= done && !load;
    end
  end
`endif
endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb_uart_rx_ovs: table-driven frames plus corner sequences, scoreboarded against delivered words.
module tb_uart_rx_ovs;
  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] baud_div = 16'd3;
  logic parity_en = 1'b0, parity_odd = 1'b0, stop2 = 1'b0, rx = 1'b1, m_ready = 1'b0;
  logic m_valid, m_perr, m_ferr, overrun, break_det, busy;
  logic [7:0] m_data;
  logic [9:0] e;
  int total = 0, bad = 0, words = 0, ovr_cnt = 0, brk_cnt = 0, w0, o0, b0;
  logic [9:0] exp_q[$];
  typedef struct {
    logic [7:0] d;
    logic pen, podd, s2, pbit, st1, st2, perr, ferr;
  } vec_t;
  vec_t vecs[8];
`ifdef UART_RX_FIFO_EN
  localparam int KEEP = 4;
`else
  localparam int KEEP = 1;
`endif
  always #5 clk = ~clk;
  uart_rx_ovs dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .parity_en(parity_en),
    .parity_odd(parity_odd), .stop2(stop2), .rx(rx), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_perr(m_perr), .m_ferr(m_ferr),
    .overrun(overrun), .break_det(break_det), .busy(busy)
  );
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(logic [7:0] d, logic pen, logic podd, logic s2, logic pbit, logic st1, logic st2);
    parity_en = pen;
    parity_odd = podd;
    stop2 = s2;
    rx = 1'b0;
    cyc(64);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      cyc(64);
    end
    if (pen) begin
      rx = pbit;
      cyc(64);
    end
    rx = st1;
    cyc(64);
    if (s2) begin
      rx = st2;
      cyc(64);
    end
    rx = 1'b1;
    cyc(64);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (overrun) ovr_cnt++;
      if (break_det) brk_cnt++;
      if (m_valid && m_ready) begin
        words++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %0h want none", m_data);
        end else begin
          e = exp_q.pop_front();
          check("m_data", 32'(m_data), 32'(e[9:2]));
          check("m_perr", 32'(m_perr), 32'(e[1]));
          check("m_ferr", 32'(m_ferr), 32'(e[0]));
        end
      end
    end
  end
  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    cyc(4);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_m_perr", 32'(m_perr), 0);
    check("rst_m_ferr", 32'(m_ferr), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_break_det", 32'(break_det), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    cyc(20);
    // word held while m_ready stays low, released one cycle after accept
    exp_q.push_back({8'hA5, 1'b0, 1'b0});
    send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(200);
    check("hold_valid", 32'(m_valid), 1);
    check("hold_data", 32'(m_data), 32'hA5);
    m_ready = 1'b1;
    cyc(1);
    check("drop_after_accept", 32'(m_valid), 0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({vecs[i].d, vecs[i].perr, vecs[i].ferr});
      send(vecs[i].d, vecs[i].pen, vecs[i].podd, vecs[i].s2, vecs[i].pbit, vecs[i].st1, vecs[i].st2);
    end
    cyc(10);
    check("table_drained", 32'(exp_q.size()), 0);
    check("table_no_break", 32'(brk_cnt), 0);
    check("table_no_overrun", 32'(ovr_cnt), 0);
    w0 = words;
    parity_en = 1'b0;
    stop2 = 1'b0;
    rx = 1'b0;
    cyc(8);
    check("false_start_busy_hi", 32'(busy), 1);
    rx = 1'b1;
    cyc(64);
    check("false_start_busy_lo", 32'(busy), 0);
    check("false_start_no_word", 32'(words - w0), 0);
    w0 = words;
    b0 = brk_cnt;
    exp_q.push_back({8'h00, 1'b0, 1'b1});
    rx = 1'b0;
    cyc(20 * 64);
    rx = 1'b1;
    cyc(128);
    check("break_pulses", 32'(brk_cnt - b0), 1);
    check("break_words", 32'(words - w0), 1);
    exp_q.push_back({8'h55, 1'b0, 1'b0});
    send(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("after_break_words", 32'(words - w0), 2);
    m_ready = 1'b0;
    o0 = ovr_cnt;
    for (int i = 0; i <= KEEP; i++) begin
      if (i < KEEP) exp_q.push_back({8'(8'h11 * (i + 1)), 1'b0, 1'b0});
      send(8'(8'h11 * (i + 1)), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    check("overrun_pulses", 32'(ovr_cnt - o0), 1);
    check("overrun_head", 32'(m_data), 32'h11);
    m_ready = 1'b1;
    cyc(20);
    check("overrun_drained", 32'(exp_q.size()), 0);
    check("overrun_empty", 32'(m_valid), 0);
    w0 = words;
    rx = 1'b0;
    cyc(64);
    rx = 1'b1;
    cyc(64);
    rx = 1'b0;
    cyc(64);
    check("mid_data_busy", 32'(busy), 1);
    rst = 1'b1;
    rx = 1'b1;
    cyc(2);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_valid", 32'(m_valid), 0);
    check("mid_rst_data", 32'(m_data), 0);
    check("mid_rst_flags", 32'({m_perr, m_ferr, overrun, break_det}), 0);
    rst = 1'b0;
    cyc(700);
    check("mid_rst_no_word", 32'(words - w0), 0);
    check("final_queue", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
